ts_sync_framer: RTL and testbench

Recovers MPEG-2 TS packet framing from a raw byte stream, one byte per valid cycle. It hunts for the 0x47 sync byte at 188-byte spacing and locks after a run of consecutive good syncs. It then flywheels through corrupted sync bytes and forwards framed bytes with start/end-of-packet markers and QoS counters. It sits directly downstream of the byte source: file stimulus in simulation, the TS input interface in hardware. One instance serves each of the four input streams.

---
 rtl/ts_sync_framer_if.sv | 25 ++
 rtl/ts_sync_framer.sv | 147 ++++++++++++++
 tb/tb_ts_sync_framer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ts_sync_framer_if.sv
// Byte-stream in / framed-stream out bundle for one TS framer instance.
interface ts_sync_framer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
);
    logic [DATA_WIDTH-1:0] byte_in;
    logic                  byte_valid;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  sop;
    logic                  eop;
    logic                  locked;
    logic [CNT_WIDTH-1:0]  pkt_count;
    logic [CNT_WIDTH-1:0]  sync_err_count;

    modport master (
        output byte_in, byte_valid,
        input  data_out, data_valid, sop, eop, locked, pkt_count, sync_err_count
    );

    modport slave (
        input  byte_in, byte_valid,
        output data_out, data_valid, sop, eop, locked, pkt_count, sync_err_count
    );
endinterface

// File: rtl/ts_sync_framer.sv
// MPEG-2 TS framer: hunts for 0x47 at PKT_LEN spacing, locks, flywheels through
// corrupted syncs and forwards whole packets with sop/eop and QoS counters.
module ts_sync_framer #(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    PKT_LEN      = 188,
    parameter logic [DATA_WIDTH-1:0] SYNC_BYTE    = 8'h47,
    parameter int                    LOCK_COUNT   = 3,
    parameter int                    UNLOCK_COUNT = 3,
    parameter int                    CNT_WIDTH    = 16
) (
    input logic clk,
    input logic rst,
    ts_sync_framer_if.slave ts
);
    localparam int POS_W = $clog2(PKT_LEN);
    localparam int GW    = $clog2(LOCK_COUNT + 1);
    localparam int MW    = $clog2(UNLOCK_COUNT + 1);

    localparam logic [POS_W-1:0] LAST_POS = POS_W'(PKT_LEN - 1);
    localparam logic [GW-1:0]    LOCK_C   = GW'(LOCK_COUNT);
    localparam logic [MW-1:0]    UNLOCK_C = MW'(UNLOCK_COUNT);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [POS_W-1:0]      pos_q, pos_d;
    logic [GW-1:0]         good_q, good_d;
    logic [MW-1:0]         miss_q, miss_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  dv_q, dv_d, sop_q, sop_d, eop_q, eop_d;
    logic [CNT_WIDTH-1:0]  pkt_q, pkt_d, err_q, err_d;

    logic             is_sync, at_sync, fwd, bad;
    logic [POS_W-1:0] pos_nxt;
    logic [GW-1:0]    good_inc;
    logic [MW-1:0]    miss_inc;

    assign is_sync  = (ts.byte_in == SYNC_BYTE);
    assign at_sync  = (pos_q == '0);
    assign pos_nxt  = (pos_q == LAST_POS) ? '0 : pos_q + 1'b1;
    assign good_inc = good_q + 1'b1;
    assign miss_inc = miss_q + 1'b1;

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        good_d  = good_q;
        miss_d  = miss_q;
        fwd     = 1'b0;
        bad     = 1'b0;
        if (ts.byte_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (is_sync) begin
                        state_d = ST_VERIFY;
                        good_d  = GW'(1);
                        pos_d   = POS_W'(1);
                    end
                end
                ST_VERIFY: begin
                    pos_d = pos_nxt;
                    if (at_sync) begin
                        if (is_sync) begin
                            good_d = good_inc;
                            if (good_inc == LOCK_C) begin
                                state_d = ST_LOCKED;
                                miss_d  = '0;
                                fwd     = 1'b1;
                            end
                        end else begin
                            // Failed candidate; this byte is deliberately not re-hunted.
                            state_d = ST_HUNT;
                            good_d  = '0;
                            pos_d   = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    pos_d = pos_nxt;
                    fwd   = 1'b1;
                    if (at_sync) begin
                        if (is_sync) begin
                            miss_d = '0;
                        end else begin
                            bad = 1'b1;
                            if (miss_inc == UNLOCK_C) begin
                                state_d = ST_HUNT;
                                pos_d   = '0;
                                good_d  = '0;
                                miss_d  = '0;
                                fwd     = 1'b0;
                            end else begin
                                miss_d = miss_inc;
                            end
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    always_comb begin
        data_d = fwd ? ts.byte_in : data_q;
        dv_d   = fwd;
        sop_d  = fwd && at_sync;
        eop_d  = fwd && (pos_q == LAST_POS);
        pkt_d  = (sop_d && pkt_q != '1) ? pkt_q + 1'b1 : pkt_q;
        err_d  = (bad && err_q != '1) ? err_q + 1'b1 : err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_HUNT;
            pos_q   <= '0;
            good_q  <= '0;
            miss_q  <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            pkt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            good_q  <= good_d;
            miss_q  <= miss_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            pkt_q   <= pkt_d;
            err_q   <= err_d;
        end
    end

    assign ts.data_out       = data_q;
    assign ts.data_valid     = dv_q;
    assign ts.sop            = sop_q;
    assign ts.eop            = eop_q;
    assign ts.locked         = (state_q == ST_LOCKED);
    assign ts.pkt_count      = pkt_q;
    assign ts.sync_err_count = err_q;
endmodule

// File: tb/tb_ts_sync_framer.sv
// Randomized/directed bench for ts_sync_framer against a phase-arithmetic model.
module tb_ts_sync_framer;
    localparam int PKT   = 188;
    localparam int LOCKC = 3;
    localparam int UNLK  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ts_sync_framer_if #(.DATA_WIDTH(8), .CNT_WIDTH(16)) tsif ();

    ts_sync_framer #(
        .DATA_WIDTH(8), .PKT_LEN(PKT), .SYNC_BYTE(8'h47),
        .LOCK_COUNT(LOCKC), .UNLOCK_COUNT(UNLK), .CNT_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ts(tsif)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model: framing phase is (valid-byte index - anchor) mod PKT.
    int         m_vidx, m_anchor, m_mode, m_good, m_miss, m_pkt, m_err;
    logic [7:0] e_data;
    bit         e_dv, e_sop, e_eop, e_lock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_vidx = 0; m_anchor = 0; m_mode = 0; m_good = 0; m_miss = 0;
        m_pkt = 0; m_err = 0;
        e_data = 8'h00; e_dv = 0; e_sop = 0; e_eop = 0; e_lock = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int ph;
        bit fwd, sync;
        sync = (b == 8'h47);
        fwd  = 0;
        ph   = (m_mode == 0) ? 0 : ((m_vidx - m_anchor) % PKT);
        if (m_mode == 0) begin
            if (sync) begin m_anchor = m_vidx; m_good = 1; m_mode = 1; end
        end else if (m_mode == 1) begin
            if (ph == 0) begin
                if (sync) begin
                    m_good++;
                    if (m_good == LOCKC) begin m_mode = 2; m_miss = 0; fwd = 1; end
                end else begin
                    m_mode = 0; m_good = 0;
                end
            end
        end else begin
            fwd = 1;
            if (ph == 0) begin
                if (sync) m_miss = 0;
                else begin
                    m_miss++;
                    if (m_err < 65535) m_err++;
                    if (m_miss == UNLK) begin m_mode = 0; m_miss = 0; fwd = 0; end
                end
            end
        end
        m_vidx++;
        e_dv  = fwd;
        e_sop = fwd && (ph == 0);
        e_eop = fwd && (ph == PKT - 1);
        if (fwd) e_data = b;
        if (e_sop && m_pkt < 65535) m_pkt++;
        e_lock = (m_mode == 2);
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            if (tsif.byte_valid) model_byte(tsif.byte_in);
            else begin e_dv = 0; e_sop = 0; e_eop = 0; end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("data_valid", 32'(tsif.data_valid), 32'(e_dv));
            chk("sop", 32'(tsif.sop), 32'(e_sop));
            chk("eop", 32'(tsif.eop), 32'(e_eop));
            chk("locked", 32'(tsif.locked), 32'(e_lock));
            chk("pkt_count", 32'(tsif.pkt_count), 32'(m_pkt));
            chk("sync_err_count", 32'(tsif.sync_err_count), 32'(m_err));
            if (e_dv) chk("data_out", 32'(tsif.data_out), 32'(e_data));
        end
    end

    task automatic send(input bit v, input logic [7:0] b);
        tsif.byte_valid = v;
        tsif.byte_in    = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_g(input logic [7:0] b, input int gap_pct);
        while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) send(1'b0, 8'($urandom));
        send(1'b1, b);
    endtask

    function automatic logic [7:0] pay(input int i, input bit no47);
        logic [7:0] b;
        b = 8'(i);
        if (no47 && b == 8'h47) b = 8'h48;
        return b;
    endfunction

    task automatic body(input int from, input int upto, input bit no47, input int gap_pct);
        for (int i = from; i <= upto; i++) send_g(pay(i, no47), gap_pct);
    endtask

    task automatic pkt(input logic [7:0] b0, input bit no47, input int gap_pct);
        send_g(b0, gap_pct);
        body(1, PKT - 1, no47, gap_pct);
    endtask

    task automatic zero_chk(input string tag);
        chk({tag, "_data_out"}, 32'(tsif.data_out), 32'h0);
        chk({tag, "_data_valid"}, 32'(tsif.data_valid), 32'h0);
        chk({tag, "_sop"}, 32'(tsif.sop), 32'h0);
        chk({tag, "_eop"}, 32'(tsif.eop), 32'h0);
        chk({tag, "_locked"}, 32'(tsif.locked), 32'h0);
        chk({tag, "_pkt_count"}, 32'(tsif.pkt_count), 32'h0);
        chk({tag, "_sync_err_count"}, 32'(tsif.sync_err_count), 32'h0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        model_reset();
        #1;
        zero_chk(tag);
        send(1'b0, 8'h00);
        send(1'b0, 8'h00);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] r;
        tsif.byte_valid = 1'b0;
        tsif.byte_in    = 8'h00;
        model_reset();
        @(posedge clk);
        #1;
        do_reset("reset");

        // Clean stream: lock with 3rd packet's first byte.
        pkt(8'h47, 1'b0, 0);
        pkt(8'h47, 1'b0, 0);
        chk("s1_unlocked_before", 32'(tsif.locked), 32'h0);
        send_g(8'h47, 0);
        chk("s1_lock_sop", 32'(tsif.sop), 32'h1);
        chk("s1_lock_locked", 32'(tsif.locked), 32'h1);
        chk("s1_lock_pkt", 32'(tsif.pkt_count), 32'h1);
        body(1, PKT - 1, 1'b0, 0);
        chk("s1_eop", 32'(tsif.eop), 32'h1);
        for (int p = 3; p < 10; p++) pkt(8'h47, 1'b0, 0);
        chk("s1_pkt_count", 32'(tsif.pkt_count), 32'd8);
        chk("s1_err", 32'(tsif.sync_err_count), 32'd0);
        send(1'b0, 8'h00);

        // Garbage with a false candidate at offset 10, then a clean stream.
        do_reset("s2_reset");
        for (int i = 0; i < 50; i++) begin
            r = 8'($urandom_range(0, 254));
            if (r >= 8'h47) r = r + 8'h01;
            send_g((i == 10) ? 8'h47 : r, 0);
        end
        for (int p = 0; p < 10; p++) pkt(8'h47, 1'b0, 0);
        chk("s2_pkt_count", 32'(tsif.pkt_count), 32'd7);
        chk("s2_err", 32'(tsif.sync_err_count), 32'd0);
        chk("s2_locked", 32'(tsif.locked), 32'd1);

        // Single corrupted sync while locked.
        do_reset("s3_reset");
        for (int p = 0; p < 4; p++) pkt(8'h47, 1'b0, 0);
        send_g(8'h00, 0);
        chk("s3_bad_sop", 32'(tsif.sop), 32'h1);
        chk("s3_bad_data", 32'(tsif.data_out), 32'h0);
        chk("s3_bad_locked", 32'(tsif.locked), 32'h1);
        chk("s3_bad_err", 32'(tsif.sync_err_count), 32'd1);
        body(1, PKT - 1, 1'b0, 0);
        for (int p = 5; p < 8; p++) pkt(8'h47, 1'b0, 0);
        chk("s3_pkt_count", 32'(tsif.pkt_count), 32'd6);

        // Lock loss after UNLOCK_COUNT bad syncs, then relock.
        do_reset("s4_reset");
        for (int p = 0; p < 4; p++) pkt(8'h47, 1'b1, 0);
        pkt(8'h00, 1'b1, 0);
        pkt(8'h00, 1'b1, 0);
        send_g(8'h00, 0);
        chk("s4_drop_locked", 32'(tsif.locked), 32'h0);
        chk("s4_drop_dv", 32'(tsif.data_valid), 32'h0);
        chk("s4_drop_err", 32'(tsif.sync_err_count), 32'd3);
        body(1, PKT - 1, 1'b1, 0);
        for (int p = 7; p < 12; p++) pkt(8'h47, 1'b1, 0);
        chk("s4_relocked", 32'(tsif.locked), 32'h1);
        chk("s4_pkt_count", 32'(tsif.pkt_count), 32'd7);
        chk("s4_err", 32'(tsif.sync_err_count), 32'd3);

        // Gapped version of the clean stream.
        do_reset("s5_reset");
        for (int p = 0; p < 10; p++) pkt(8'h47, 1'b0, 50);
        send(1'b0, 8'h00);
        chk("s5_pkt_count", 32'(tsif.pkt_count), 32'd8);
        chk("s5_err", 32'(tsif.sync_err_count), 32'd0);

        // Reset mid-packet, then restart from HUNT.
        do_reset("s6_reset");
        for (int p = 0; p < 3; p++) pkt(8'h47, 1'b1, 0);
        send_g(8'h47, 0);
        body(1, 90, 1'b1, 0);
        chk("s6_pre_locked", 32'(tsif.locked), 32'h1);
        tsif.byte_valid = 1'b0;
        do_reset("s6_mid");
        for (int p = 0; p < 4; p++) pkt(8'h47, 1'b1, 0);
        send(1'b0, 8'h00);
        chk("s6_pkt_count", 32'(tsif.pkt_count), 32'd2);
        chk("s6_locked", 32'(tsif.locked), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
